// File: rtl/ambiente_robo.sv
// Grid-world plant for the wall-following robot: turns avancar/girar into position,
// heading and head/left wall sensing. Define AMBIENTE_WRAP_EN for a toroidal grid.
module ambiente_robo #(
  parameter int DIM_BITS  = 3,
  parameter int START_X   = 0,
  parameter int START_Y   = 0,
  parameter int START_DIR = 1,
  parameter logic [(1<<(2*DIM_BITS))-1:0] MAP_INIT = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                avancar,
  input  logic                girar,
  input  logic                map_we,
  input  logic [DIM_BITS-1:0] map_x,
  input  logic [DIM_BITS-1:0] map_y,
  input  logic                map_val,
  output logic                head,
  output logic                left,
  output logic [DIM_BITS-1:0] pos_x,
  output logic [DIM_BITS-1:0] pos_y,
  output logic [1:0]          dir,
  output logic                colisao,
  output logic                erro,
  output logic [15:0]         passos
);

  localparam int CELLS = 1 << (2*DIM_BITS);
`ifdef AMBIENTE_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  logic [DIM_BITS-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]          dir_q, dir_d;
  logic [CELLS-1:0]    map_q, map_d;
  logic [15:0]         passos_q, passos_d;
  logic                colisao_q, colisao_d, erro_q, erro_d;

  // Returns {off_grid, ny, nx}; coordinates always wrap, off_grid flags a border crossing.
  function automatic logic [2*DIM_BITS:0] nbr(input logic [1:0] d,
                                              input logic [DIM_BITS-1:0] x,
                                              input logic [DIM_BITS-1:0] y);
    logic [DIM_BITS-1:0] nx, ny;
    logic                off;
    nx  = x;
    ny  = y;
    off = 1'b0;
    case (d)
      2'd0:    begin ny = y - DIM_BITS'(1); off = (y == '0); end
      2'd1:    begin nx = x + DIM_BITS'(1); off = (x == '1); end
      2'd2:    begin ny = y + DIM_BITS'(1); off = (y == '1); end
      default: begin nx = x - DIM_BITS'(1); off = (x == '0); end
    endcase
    return {off, ny, nx};
  endfunction

  logic                a_off, l_off;
  logic [DIM_BITS-1:0] a_x, a_y, l_x, l_y;
  logic                wr_self, wr_block;

  assign {a_off, a_y, a_x} = nbr(dir_q, x_q, y_q);
  assign {l_off, l_y, l_x} = nbr(dir_q - 2'd1, x_q, y_q);

  assign head = (a_off & ~WRAP) | map_q[{a_y, a_x}];
  assign left = (l_off & ~WRAP) | map_q[{l_y, l_x}];

  // A wall written onto the move destination in the same cycle wins over the move.
  assign wr_self  = ({map_y, map_x} == {y_q, x_q});
  assign wr_block = map_we & map_val & ({map_y, map_x} == {a_y, a_x});

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    map_d     = map_q;
    passos_d  = passos_q;
    colisao_d = 1'b0;
    erro_d    = 1'b0;
    if (map_we && !wr_self) map_d[{map_y, map_x}] = map_val;
    if (avancar && girar) begin
      erro_d = 1'b1;
    end else if (avancar) begin
      if (head || wr_block) begin
        colisao_d = 1'b1;
      end else begin
        x_d = a_x;
        y_d = a_y;
        if (passos_q != 16'hFFFF) passos_d = passos_q + 16'd1;
      end
    end else if (girar) begin
      dir_d = dir_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q       <= START_X[DIM_BITS-1:0];
      y_q       <= START_Y[DIM_BITS-1:0];
      dir_q     <= START_DIR[1:0];
      map_q     <= MAP_INIT;
      passos_q  <= 16'd0;
      colisao_q <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      map_q     <= map_d;
      passos_q  <= passos_d;
      colisao_q <= colisao_d;
      erro_q    <= erro_d;
    end
  end

  assign pos_x   = x_q;
  assign pos_y   = y_q;
  assign dir     = dir_q;
  assign colisao = colisao_q;
  assign erro    = erro_q;
  assign passos  = passos_q;

endmodule
